// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared defaults and sizing helper for the N-to-1 arbitrated mux
//
// Purpose: default channel width and count, plus a select-width helper that
//          stays at least 1 bit wide for degenerate channel counts.
// Ports:   none (package)
package mux_arb_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NUM_IN = 4;

  // $clog2(1) is 0, which would give a zero-width index; clamp to 1 bit.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_nto1_if.sv
// rtl/mux_arb_nto1_if.sv - handshake bundle between producers, the arbitrated mux and its consumer
//
// Purpose: groups the per-channel input handshake, the flush control and the
//          registered output handshake of mux_arb_nto1.
// Signals: in_data   [NUM_IN*WIDTH] channel i at [i*WIDTH +: WIDTH]
//          in_valid  [NUM_IN]       channel i has a word
//          in_ready  [NUM_IN]       channel i word accepted (one-hot or zero)
//          flush                    discard the output register
//          out_data  [WIDTH]        registered selected word
//          out_chan  [SEL_W]        channel that supplied out_data
//          out_valid                out_data/out_chan valid
//          out_ready                consumer accepts the current word
// Modports: master = producers + consumer side, slave = the mux.
interface mux_arb_nto1_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = DEFAULT_NUM_IN
);

  localparam int SEL_W = sel_w(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output flush,
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  flush,
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/mux_arb_nto1_rr_picker.sv
// rtl/mux_arb_nto1_rr_picker.sv - combinational rotating-priority picker
//
// Purpose: picks the first set request bit searching base, base+1, ...
//          modulo N. With base tied to 0 it degenerates to lowest-index-wins.
// Ports:   req  [N]     request vector
//          base [SEL_W] highest-priority index (must be < N)
//          gnt  [N]     one-hot grant, zero when no request
//          idx  [SEL_W] index of the granted bit, 0 when no request
//          any          at least one request present
module rr_picker
  import mux_arb_pkg::*;
#(
  parameter int N     = DEFAULT_NUM_IN,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // Modulo keeps the candidate in range even for non-power-of-2 N.
      cand = SEL_W'((int'(base) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// rtl/mux_arb_nto1.sv - N-input arbitrated mux feeding one registered output stage
//
// Purpose: each cycle grants one requesting channel and captures its word into
//          a single output register with its own valid/ready handshake.
//          Drain and load in the same cycle give full throughput.
// Ports:   Clk    rising-edge clock
//          Reset  asynchronous, active-high reset
//          bus    mux_arb_nto1_if.slave (inputs, flush, registered output)
// Config:  MUX_ARB_RR_EN defined -> round-robin arbitration with a pointer
//          register; undefined -> fixed priority, lowest index wins.
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = DEFAULT_NUM_IN
) (
  input  logic         Clk,
  input  logic         Reset,
  mux_arb_nto1_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_IN);

  logic [NUM_IN-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [SEL_W-1:0]  base;
  logic              load_ok;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_chan_q,  out_chan_d;

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  assign base = ptr_q;

  // Next priority goes to the channel after the winner; wrap explicitly so a
  // non-power-of-2 channel count never produces an out-of-range pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign base = '0;
`endif

  rr_picker #(
    .N     (NUM_IN),
    .SEL_W (SEL_W)
  ) u_picker (
    .req  (bus.in_valid),
    .base (base),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  // Flush wins over any load so the discarded cycle never swallows a word.
  assign load_ok = (!out_valid_q || bus.out_ready) && !bus.flush;
  assign xfer    = load_ok && gnt_any && !Reset;

  // One-hot AND-OR select keeps the data path free of variable part-selects.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (xfer) begin
      bus.in_ready = gnt;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_chan_d  = gnt_idx;
    end else if (out_valid_q && bus.out_ready) begin
      // Drained with nothing behind it; data/chan keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb/tb_mux_arb_nto1.sv - directed table-driven bench for mux_arb_nto1 (4-input and 3-input instances)
module tb_mux_arb_nto1;

`ifdef MUX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] base;
    logic        ordy;
    logic        fl;
    logic [3:0]  eir;
    logic        eov;
    logic [31:0] edata;
    logic [1:0]  echan;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  mux_arb_nto1_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
  mux_arb_nto1_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

  mux_arb_nto1 #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus4)
  );

  mux_arb_nto1 #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus3)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] iv, input logic [31:0] base, input logic ordy, input logic fl);
    bus4.in_valid  = iv;
    bus4.out_ready = ordy;
    bus4.flush     = fl;
    for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = base + 32'(i);
  endtask

  initial begin
    // Idle, contention x5, single channel, drain, backpressure, flush.
    vecs[0]  = '{4'b0000, 32'h0,        1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0};
    vecs[1]  = '{4'b1111, 32'h10000000, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h10000000, 2'd0};
    vecs[2]  = '{4'b1111, 32'h10000000, 1'b1, 1'b0, RR ? 4'b0010 : 4'b0001, 1'b1,
                 RR ? 32'h10000001 : 32'h10000000, RR ? 2'd1 : 2'd0};
    vecs[3]  = '{4'b1111, 32'h10000000, 1'b1, 1'b0, RR ? 4'b0100 : 4'b0001, 1'b1,
                 RR ? 32'h10000002 : 32'h10000000, RR ? 2'd2 : 2'd0};
    vecs[4]  = '{4'b1111, 32'h10000000, 1'b1, 1'b0, RR ? 4'b1000 : 4'b0001, 1'b1,
                 RR ? 32'h10000003 : 32'h10000000, RR ? 2'd3 : 2'd0};
    vecs[5]  = '{4'b1111, 32'h10000000, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h10000000, 2'd0};
    vecs[6]  = '{4'b0100, 32'hDEADBEED, 1'b1, 1'b0, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    vecs[7]  = '{4'b0000, 32'h0,        1'b1, 1'b0, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
    vecs[8]  = '{4'b0011, 32'h20000000, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h20000000, 2'd0};
    vecs[9]  = '{4'b0011, 32'h30000000, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h20000000, 2'd0};
    vecs[10] = '{4'b0011, 32'h30000000, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h20000000, 2'd0};
    vecs[11] = '{4'b0011, 32'h30000000, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h20000000, 2'd0};
    vecs[12] = '{4'b0011, 32'h30000000, 1'b1, 1'b0, RR ? 4'b0010 : 4'b0001, 1'b1,
                 RR ? 32'h30000001 : 32'h30000000, RR ? 2'd1 : 2'd0};
    vecs[13] = '{4'b0001, 32'h40000000, 1'b0, 1'b1, 4'b0000, 1'b0,
                 RR ? 32'h30000001 : 32'h30000000, RR ? 2'd1 : 2'd0};
    vecs[14] = '{4'b0001, 32'h40000000, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h40000000, 2'd0};

    Reset = 1'b1;
    drive4(4'b0000, 32'h0, 1'b0, 1'b0);
    bus3.in_valid  = '0;
    bus3.in_data   = '0;
    bus3.flush     = 1'b0;
    bus3.out_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("reset_out_data", bus4.out_data, 32'd0);
    chk("reset_out_chan", 32'(bus4.out_chan), 32'd0);
    Reset = 1'b0;

    for (int r = 0; r < 15; r++) begin
      drive4(vecs[r].iv, vecs[r].base, vecs[r].ordy, vecs[r].fl);
      #1;
      chk($sformatf("row%0d_in_ready", r), 32'(bus4.in_ready), 32'(vecs[r].eir));
      @(posedge Clk);
      #1;
      chk($sformatf("row%0d_out_valid", r), 32'(bus4.out_valid), 32'(vecs[r].eov));
      chk($sformatf("row%0d_out_data", r), bus4.out_data, vecs[r].edata);
      chk($sformatf("row%0d_out_chan", r), 32'(bus4.out_chan), 32'(vecs[r].echan));
    end

    // Stall, then asynchronous reset mid-stall.
    drive4(4'b0011, 32'h50000000, 1'b0, 1'b0);
    #1;
    chk("stall_in_ready", 32'(bus4.in_ready), 32'd0);
    @(posedge Clk);
    #1;
    chk("stall_out_valid", 32'(bus4.out_valid), 32'd1);
    chk("stall_out_data", bus4.out_data, 32'h40000000);
    bus4.out_ready = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("async_rst_out_data", bus4.out_data, 32'd0);
    chk("async_rst_out_chan", 32'(bus4.out_chan), 32'd0);
    chk("async_rst_in_ready", 32'(bus4.in_ready), 32'd0);
    @(posedge Clk);
    #1;
    chk("rst_held_in_ready", 32'(bus4.in_ready), 32'd0);
    chk("rst_held_out_valid", 32'(bus4.out_valid), 32'd0);
    Reset = 1'b0;

    // Pointer restarts at channel 0 after reset.
    drive4(4'b1111, 32'h70000000, 1'b1, 1'b0);
    #1;
    chk("post_rst_in_ready", 32'(bus4.in_ready), 32'b0001);
    @(posedge Clk);
    #1;
    chk("post_rst_out_chan", 32'(bus4.out_chan), 32'd0);
    chk("post_rst_out_data", bus4.out_data, 32'h70000000);
    drive4(4'b0000, 32'h0, 1'b1, 1'b0);

    // Three-channel wrap: channels 0 and 2 requesting.
    bus3.in_valid  = 3'b101;
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) bus3.in_data[i*32 +: 32] = 32'h60000000 + 32'(i);
    for (int j = 0; j < 4; j++) begin
      logic [1:0] ech;
      ech = (RR && (j % 2 == 1)) ? 2'd2 : 2'd0;
      #1;
      chk($sformatf("wrap%0d_in_ready", j), 32'(bus3.in_ready), (ech == 2'd2) ? 32'b100 : 32'b001);
      @(posedge Clk);
      #1;
      chk($sformatf("wrap%0d_out_chan", j), 32'(bus3.out_chan), 32'(ech));
      chk($sformatf("wrap%0d_out_data", j), bus3.out_data, 32'h60000000 + 32'(ech));
      chk($sformatf("wrap%0d_out_valid", j), 32'(bus3.out_valid), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
